mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit for the multicycle MIPS datapath. It takes the A and B register values (rs, rt), runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, and writes the sign-corrected result into its HI/LO output registers. The control FSM starts it and waits on `busy`/`done`. The HI and LO datapath registers load from `hi`/`lo` when `done` is high.

---
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide for the multicycle datapath.
// Both operations run on operand magnitudes, one bit per cycle for WIDTH cycles,
// and the signs are applied in FIX. A divide by zero goes straight to FIX and
// leaves hi/lo untouched.
//
// state | meaning
// IDLE  | waiting for start with a valid op
// RUN   | one shift-add (mult) or restoring-subtract (div) step per cycle
// FIX   | sign correction, result load into hi/lo, done pulse
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               op_div, a_neg, b_neg, zero_flag;
    logic [CW-1:0]      cnt;

    logic               accept, req_div, b_zero;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Request decode; only 01 and 10 are real operations.
    always_comb begin
        req_div = (op == 2'b10);
        accept  = start && ((op == 2'b01) || (op == 2'b10));
        b_zero  = (b == '0);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (req_div && b_zero) ? FIX : RUN;
            RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Per-iteration arithmetic and final sign correction.
    // For div, acc holds {remainder, quotient}; the quotient half starts as the dividend.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift - {1'b0, mag_b};
        prod_fix  = (a_neg ^ b_neg) ? -acc : acc;
        quo_fix   = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            op_div    <= 1'b0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            zero_flag <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div    <= req_div;
                        a_neg     <= a[WIDTH-1];
                        b_neg     <= b[WIDTH-1];
                        mag_a     <= a[WIDTH-1] ? -a : a;
                        mag_b     <= b[WIDTH-1] ? -b : b;
                        zero_flag <= req_div && b_zero;
                        cnt       <= '0;
                        acc       <= req_div ? {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)} : '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_div) begin
                        acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        mag_b <= mag_b >> 1;
                    end
                end
                FIX: begin
                    if (!zero_flag) begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= (state == FIX);
            div_zero <= (state == FIX) && zero_flag;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each issued operation pushes its expected
// {hi, lo, div_zero}; a monitor pops and compares whenever done is high.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input int elat, input int inj);
        int n, nb;
        bit got;
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = edz;
        exp_q.push_back(e);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        nb = busy ? 1 : 0;
        got = 0;
        while (!got && n < 200) begin
            if (inj != 0 && n == inj - 1) begin
                start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd0;
            end else if (inj != 0 && n == inj) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1;
            else if (busy) nb++;
        end
        chk("latency", 64'(got ? n : -1), 64'(elat));
        chk("busy_cycles", 64'(nb), 64'(elat));
        op = 2'b00;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        do_op(2'b01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 0);
        do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0);
        do_op(2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 0);
        do_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 0);
        do_op(2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 33, 0);
        do_op(2'b10, 32'd9,        32'd0,        32'd0,        32'd15,       1'b1, 1,  0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33, 0);
        do_op(2'b01, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 33, 5);

        // Abort a multiply mid-run with reset; no done may follow.
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'b00;
        repeat (10) @(posedge clk);
        #2;
        chk("busy_before_abort", {63'd0, busy}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_div_zero", {63'd0, div_zero}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_abort", {63'd0, busy}, 64'd0);

        do_op(2'b01, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0, 33, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
